// File: rtl/sccb_arb_pkg.sv
// Shared types and helpers for the SCCB arbiter: FSM states, requester ids
// and the watchdog cycle-count calculation.
package sccb_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  typedef enum logic {REQ_A, REQ_B} req_id_t;

  localparam int unsigned ACK_WAIT_DEFAULT = 4;

  function automatic logic [31:0] timeout_cycles(input int unsigned clk_freq,
                                                 input int unsigned timeout_ms);
    return 32'(timeout_ms * (clk_freq / 1000));
  endfunction

endpackage

// File: rtl/sccb_arb_req_slot.sv
// One-deep command buffer for a single requester; a start while full is
// dropped and reported as an overrun.
module sccb_arb_req_slot
  import sccb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  input  logic       clear_cmd,
  output logic       pending,
  output logic       ready,
  output logic       overrun,
  output logic [7:0] addr,
  output logic [7:0] data
);

  // clear_cmd only fires while pending is set, so it never races a capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      addr    <= 8'h00;
      data    <= 8'h00;
    end else if (start && !pending) begin
      pending <= 1'b1;
      addr    <= addr_in;
      data    <= data_in;
    end else if (clear_cmd) begin
      pending <= 1'b0;
    end
  end

  assign ready   = ~pending;
  assign overrun = start & pending;

endmodule

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB master between the config sequencer (A)
// and the runtime register writer (B), with ack/stall watchdogs.
module sccb_arbiter
  import sccb_arb_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned TIMEOUT_MS = 2,
  parameter int unsigned ACK_WAIT   = ACK_WAIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_start,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  output logic       a_done,
  input  logic       b_start,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       b_done,
  input  logic       SCCB_interface_ready,
  output logic       SCCB_interface_start,
  output logic [7:0] SCCB_interface_addr,
  output logic [7:0] SCCB_interface_data,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_overrun,
  input  logic       err_clear
);

  localparam logic [31:0] TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ, TIMEOUT_MS);

  state_t      state;
  req_id_t     grant, last_grant, next_grant;
  logic [15:0] ack_cnt;
  logic [31:0] wd_cnt;
  logic        pend_a, pend_b, ovr_a, ovr_b;
  logic [7:0]  slot_a_addr, slot_a_data, slot_b_addr, slot_b_data;
  logic        finish, abort, clr_a, clr_b;

  sccb_arb_req_slot u_slot_a (
    .clk(clk), .rst(rst), .start(a_start), .addr_in(a_addr), .data_in(a_data),
    .clear_cmd(clr_a), .pending(pend_a), .ready(a_ready), .overrun(ovr_a),
    .addr(slot_a_addr), .data(slot_a_data)
  );

  sccb_arb_req_slot u_slot_b (
    .clk(clk), .rst(rst), .start(b_start), .addr_in(b_addr), .data_in(b_data),
    .clear_cmd(clr_b), .pending(pend_b), .ready(b_ready), .overrun(ovr_b),
    .addr(slot_b_addr), .data(slot_b_data)
  );

  // Completion and both watchdog aborts release the granted buffer on the same edge
  always_comb begin
    finish = (state == WAIT_DONE) && SCCB_interface_ready;
    abort  = ((state == WAIT_BUSY) && SCCB_interface_ready && (ack_cnt == 16'd0)) ||
             ((state == WAIT_DONE) && !SCCB_interface_ready && (wd_cnt == 32'd0));
    clr_a  = (finish || abort) && (grant == REQ_A);
    clr_b  = (finish || abort) && (grant == REQ_B);
    if (pend_a && pend_b)
      next_grant = (last_grant == REQ_B) ? REQ_A : REQ_B;
    else if (pend_a)
      next_grant = REQ_A;
    else
      next_grant = REQ_B;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      grant                <= REQ_A;
      last_grant           <= REQ_B;
      ack_cnt              <= 16'd0;
      wd_cnt               <= 32'd0;
      SCCB_interface_start <= 1'b0;
      SCCB_interface_addr  <= 8'h00;
      SCCB_interface_data  <= 8'h00;
      a_done               <= 1'b0;
      b_done               <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      SCCB_interface_start <= 1'b0;
      a_done               <= 1'b0;
      b_done               <= 1'b0;
      unique case (state)
        IDLE: begin
          if ((pend_a || pend_b) && SCCB_interface_ready) begin
            grant                <= next_grant;
            state                <= ISSUE;
            busy                 <= 1'b1;
            SCCB_interface_start <= 1'b1;
            SCCB_interface_addr  <= (next_grant == REQ_A) ? slot_a_addr : slot_b_addr;
            SCCB_interface_data  <= (next_grant == REQ_A) ? slot_a_data : slot_b_data;
          end
        end
        ISSUE: begin
          ack_cnt <= 16'(ACK_WAIT);
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!SCCB_interface_ready) begin
            wd_cnt <= TIMEOUT_CYCLES;
            state  <= WAIT_DONE;
          end else if (ack_cnt == 16'd0) begin
            state      <= IDLE;
            busy       <= 1'b0;
            last_grant <= grant;
          end else begin
            ack_cnt <= ack_cnt - 16'd1;
          end
        end
        WAIT_DONE: begin
          if (SCCB_interface_ready) begin
            a_done     <= (grant == REQ_A);
            b_done     <= (grant == REQ_B);
            state      <= IDLE;
            busy       <= 1'b0;
            last_grant <= grant;
          end else if (wd_cnt == 32'd0) begin
            state      <= IDLE;
            busy       <= 1'b0;
            last_grant <= grant;
          end else begin
            wd_cnt <= wd_cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new error event outranks a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (abort)
        err_timeout <= 1'b1;
      else if (err_clear)
        err_timeout <= 1'b0;
      if (ovr_a || ovr_b)
        err_overrun <= 1'b1;
      else if (err_clear)
        err_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sccb_arbiter.sv
// Scoreboard bench for sccb_arbiter: directed requests push expected SCCB
// issues and done pulses; a monitor pops and compares them as they appear.
module tb_sccb_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_start = 1'b0, b_start = 1'b0;
  logic [7:0] a_addr = 8'h00, a_data = 8'h00, b_addr = 8'h00, b_data = 8'h00;
  logic       a_ready, a_done, b_ready, b_done;
  logic       sccb_ready = 1'b1;
  logic       sccb_start;
  logic [7:0] sccb_addr, sccb_data;
  logic       busy, err_timeout, err_overrun;
  logic       err_clear = 1'b0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } issue_t;

  issue_t exp_issue[$];
  int     exp_done[$];
  int     checks = 0;
  int     passed = 0;
  int     master_mode = 0;
  logic   stall_release = 1'b0;

  sccb_arbiter #(.CLK_FREQ(1000000), .TIMEOUT_MS(1), .ACK_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_start(a_start), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready), .a_done(a_done),
    .b_start(b_start), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready), .b_done(b_done),
    .SCCB_interface_ready(sccb_ready), .SCCB_interface_start(sccb_start),
    .SCCB_interface_addr(sccb_addr), .SCCB_interface_data(sccb_data),
    .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual >= lo && actual <= hi) passed++;
    else $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, actual, lo, hi);
  endtask

  task automatic recordFail(input string name);
    checks++;
    $display("[TB] FAIL %s: event occurred, required none", name);
  endtask

  task automatic expectIssue(input logic [7:0] addr, input logic [7:0] data);
    issue_t e;
    e.addr = addr;
    e.data = data;
    exp_issue.push_back(e);
  endtask

  task automatic applyStimulus(input logic use_a, input logic use_b,
                               input logic [7:0] aa, input logic [7:0] ad,
                               input logic [7:0] ba, input logic [7:0] bd);
    @(posedge clk);
    #1;
    a_start = use_a; a_addr = aa; a_data = ad;
    b_start = use_b; b_addr = ba; b_data = bd;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic pulseClear();
    @(posedge clk);
    #1 err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitQuiet(input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(!busy && a_ready && b_ready && sccb_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) recordFail(name);
  endtask

  // SCCB master model: mode 0 acks and finishes after 50 cycles, 1 never acks, 2 stalls
  initial begin
    forever begin
      @(posedge clk);
      if (sccb_start === 1'b1 && master_mode != 1) begin
        @(posedge clk);
        #1 sccb_ready = 1'b0;
        if (master_mode == 2) begin
          while (!stall_release && !rst) @(posedge clk);
        end else begin
          for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (rst) break;
          end
        end
        #1 sccb_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (sccb_start === 1'b1) begin
      if (exp_issue.size() == 0) recordFail("unexpected_issue");
      else begin
        issue_t e;
        e = exp_issue.pop_front();
        checkOutput("issue_addr", 32'(sccb_addr), 32'(e.addr));
        checkOutput("issue_data", 32'(sccb_data), 32'(e.data));
      end
    end
    if (a_done === 1'b1 && b_done === 1'b1) recordFail("done_both");
    else if (a_done === 1'b1 || b_done === 1'b1) begin
      if (exp_done.size() == 0) recordFail("unexpected_done");
      else checkOutput("done_id", 32'(b_done), 32'(exp_done.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_a_ready", 32'(a_ready), 1);
    checkOutput("rst_b_ready", 32'(b_ready), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_start", 32'(sccb_start), 0);
    checkOutput("rst_addr", 32'(sccb_addr), 0);
    checkOutput("rst_data", 32'(sccb_data), 0);
    checkOutput("rst_err_timeout", 32'(err_timeout), 0);
    checkOutput("rst_err_overrun", 32'(err_overrun), 0);

    // simultaneous pairs: A first both times
    expectIssue(8'h3A, 8'h04); expectIssue(8'h10, 8'h55);
    exp_done.push_back(0); exp_done.push_back(1);
    applyStimulus(1'b1, 1'b1, 8'h3A, 8'h04, 8'h10, 8'h55);
    waitQuiet(400, "pair1_timeout");
    expectIssue(8'h21, 8'h11); expectIssue(8'h22, 8'h22);
    exp_done.push_back(0); exp_done.push_back(1);
    applyStimulus(1'b1, 1'b1, 8'h21, 8'h11, 8'h22, 8'h22);
    waitQuiet(400, "pair2_timeout");

    // single write with latency check
    expectIssue(8'h12, 8'h80);
    exp_done.push_back(0);
    applyStimulus(1'b1, 1'b0, 8'h12, 8'h80, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("latency_k_start", 32'(sccb_start), 0);
    @(negedge clk);
    checkOutput("latency_k1_start", 32'(sccb_start), 1);
    checkOutput("latency_k1_busy", 32'(busy), 1);
    waitQuiet(200, "single_timeout");

    // overrun on B
    expectIssue(8'h40, 8'h01);
    exp_done.push_back(1);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h40, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h41, 8'h02);
    @(negedge clk);
    checkOutput("overrun_flag", 32'(err_overrun), 1);
    checkOutput("overrun_b_ready", 32'(b_ready), 0);
    waitQuiet(200, "overrun_timeout");
    checkOutput("overrun_sticky", 32'(err_overrun), 1);
    checkOutput("overrun_no_timeout", 32'(err_timeout), 0);
    pulseClear();
    checkOutput("overrun_cleared", 32'(err_overrun), 0);

    // no acknowledge from master
    master_mode = 1;
    expectIssue(8'h33, 8'h44);
    applyStimulus(1'b1, 1'b0, 8'h33, 8'h44, 8'h00, 8'h00);
    n = 0;
    while (!err_timeout && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkRange("noack_latency", n, 6, 9);
    checkOutput("noack_a_ready", 32'(a_ready), 1);
    checkOutput("noack_busy", 32'(busy), 0);
    master_mode = 0;
    pulseClear();
    checkOutput("noack_cleared", 32'(err_timeout), 0);

    // stalled master, B queued behind the stalled A
    master_mode = 2;
    expectIssue(8'h55, 8'h66);
    expectIssue(8'h77, 8'h88);
    exp_done.push_back(1);
    applyStimulus(1'b1, 1'b0, 8'h55, 8'h66, 8'h00, 8'h00);
    n = 0;
    while (!err_timeout && n < 1200) begin
      @(negedge clk);
      n++;
      if (n == 10) begin b_start = 1'b1; b_addr = 8'h77; b_data = 8'h88; end
      if (n == 11) b_start = 1'b0;
    end
    checkRange("stall_latency", n, 1000, 1012);
    checkOutput("stall_err_timeout", 32'(err_timeout), 1);
    checkOutput("stall_a_ready", 32'(a_ready), 1);
    master_mode = 0;
    stall_release = 1'b1;
    waitQuiet(300, "stall_b_timeout");
    stall_release = 1'b0;
    pulseClear();
    checkOutput("stall_cleared", 32'(err_timeout), 0);

    // reset during WAIT_DONE
    expectIssue(8'h99, 8'hAA);
    applyStimulus(1'b1, 1'b0, 8'h99, 8'hAA, 8'h00, 8'h00);
    repeat (10) @(negedge clk);
    checkOutput("midrst_busy_before", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_start", 32'(sccb_start), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_a_done", 32'(a_done), 0);
    checkOutput("midrst_a_ready", 32'(a_ready), 1);
    checkOutput("midrst_b_ready", 32'(b_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    waitQuiet(100, "midrst_recover_timeout");
    expectIssue(8'h5A, 8'hA5);
    exp_done.push_back(0);
    applyStimulus(1'b1, 1'b0, 8'h5A, 8'hA5, 8'h00, 8'h00);
    waitQuiet(200, "post_rst_timeout");

    repeat (3) @(negedge clk);
    checkOutput("issue_queue_empty", 32'(exp_issue.size()), 0);
    checkOutput("done_queue_empty", 32'(exp_done.size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
